// File: rtl/fft16_pkg.sv
// Shared constants and types for the
// 16-point radix-4 FFT front end.
package fft16_pkg;

   localparam int DATA_W   = 32;
   localparam int N_POINTS = 16;
   localparam int RADIX    = 4;
   localparam int GROUPS   = 4;
   localparam int CNT_W    = $clog2(N_POINTS);
   localparam int GRP_W    = $clog2(GROUPS);

   typedef enum logic {
      LOAD,
      ISSUE
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;

endpackage

// File: rtl/fft16_sample_buf.sv
// 16-entry complex sample store, one write port
// and four stride-4 read ports (k, k+4, k+8, k+12).
module fft16_sample_buf
   import fft16_pkg::*;
(
   input  logic                   clk,
   input  logic                   we,
   input  logic [CNT_W-1:0]       waddr,
   input  cplx_t                  wdata,
   input  logic [GRP_W-1:0]       k,
   output cplx_t [RADIX-1:0]      rd
);

   cplx_t mem [N_POINTS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   for (genvar g = 0; g < RADIX; g++) begin : g_rd
      assign rd[g] = mem[{2'(g), k}];
   end

endmodule

// File: rtl/fft16_input_loader.sv
// Buffers a natural-order 16-sample frame and issues
// the four radix-4 DIF input groups with twiddle index.
module fft16_input_loader
   import fft16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_im,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_idx,
   output logic [DATA_W-1:0] out_0_real,
   output logic [DATA_W-1:0] out_0_im,
   output logic [DATA_W-1:0] out_1_real,
   output logic [DATA_W-1:0] out_1_im,
   output logic [DATA_W-1:0] out_2_real,
   output logic [DATA_W-1:0] out_2_im,
   output logic [DATA_W-1:0] out_3_real,
   output logic [DATA_W-1:0] out_3_im,
   output logic              out_last,
   output logic              frame_err
);

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  wr_cnt;
   logic [GRP_W-1:0]  grp;
   logic [GRP_W-1:0]  rd_k;
   cplx_t             wdata;
   cplx_t [RADIX-1:0] rd;
   cplx_t [RADIX-1:0] ob;
   logic              acc;
   logic              fire;
   logic              cnt_end;
   logic              grp_end;

   assign in_ready = (state == LOAD);
   assign acc      = in_valid & in_ready;
   assign fire     = out_valid & out_ready;
   assign cnt_end  = (wr_cnt == CNT_W'(N_POINTS - 1));
   assign grp_end  = (grp == GRP_W'(GROUPS - 1));
   assign wdata    = '{re: in_real, im: in_im};

   // Read port points at the group about to be loaded.
   assign rd_k = (state == ISSUE) ? grp + 1'b1 : '0;

   fft16_sample_buf u_buf (
      .clk   (clk),
      .we    (acc),
      .waddr (wr_cnt),
      .wdata (wdata),
      .k     (rd_k),
      .rd    (rd)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         LOAD:    if (acc && cnt_end)  state_nx = ISSUE;
         ISSUE:   if (fire && grp_end) state_nx = LOAD;
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         wr_cnt    <= '0;
         grp       <= '0;
         out_valid <= 1'b0;
         ob        <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         frame_err <= acc & (in_last ^ cnt_end);
         if (acc) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (acc && cnt_end) begin
            grp       <= '0;
            out_valid <= 1'b1;
            ob        <= rd;
         end else if (fire) begin
            if (grp_end) begin
               out_valid <= 1'b0;
            end else begin
               grp <= grp + 1'b1;
               ob  <= rd;
            end
         end
      end
   end

   assign out_idx    = grp;
   assign out_last   = grp_end & out_valid;
   assign out_0_real = ob[0].re;
   assign out_0_im   = ob[0].im;
   assign out_1_real = ob[1].re;
   assign out_1_im   = ob[1].im;
   assign out_2_real = ob[2].re;
   assign out_2_im   = ob[2].im;
   assign out_3_real = ob[3].re;
   assign out_3_im   = ob[3].im;

endmodule

// File: doc/fft16_input_loader.md
Name: fft16_input_loader

Overview:
Front-end stage of the 16-point radix-4 FFT, directly upstream of the first-stage butterfly. It accepts one complex IEEE-754 single-precision sample per handshake in natural order and buffers a full 16-sample frame. It then issues four radix-4 DIF input groups, x[k], x[k+4], x[k+8], x[k+12] for k=0..3, each with its twiddle index k. The index drives the butterfly's mux_1_out select.

Parameters:
DATA_W  32  width of each real/imag word (IEEE-754 single, passed through untouched)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  loader can accept a sample
in_real  in  DATA_W  sample real part
in_im  in  DATA_W  sample imaginary part
in_last  in  1  marks the 16th sample of a frame (checked only)
out_valid  out  1  group valid
out_ready  in  1  downstream accepts group
out_idx  out  2  group index k, feeds mux_1_out
out_0_real, out_0_im  out  DATA_W each  x[k]
out_1_real, out_1_im  out  DATA_W each  x[k+4]
out_2_real, out_2_im  out  DATA_W each  x[k+8]
out_3_real, out_3_im  out  DATA_W each  x[k+12]
out_last  out  1  high with group k=3
frame_err  out  1  one-cycle pulse on an in_last mismatch

Behaviour:
- States: LOAD, ISSUE. Reset state is LOAD.
- Reset values: wr_cnt=0, grp=0, out_valid=0, out_idx=0, all out data=0, out_last=0, frame_err=0. Buffer contents are don't-care.
- in_ready = (state==LOAD), combinational from state only. It is 1 immediately after reset.
- LOAD:
  - Each in_valid&in_ready edge writes buf[wr_cnt] and increments wr_cnt.
  - On the accept with wr_cnt==15: wr_cnt wraps to 0, state goes to ISSUE, grp=0, out_valid=1, and the out regs load group 0 (buf[0], buf[4], buf[8], buf[12]).
  - Latency: out_valid is high in the cycle after the 16th accept.
- ISSUE:
  - in_ready=0. The input side is stalled.
  - While out_valid & !out_ready, all outputs hold stable.
  - On out_valid&out_ready with grp<3: grp increments and the out regs load the next group.
  - On out_valid&out_ready with grp==3: out_valid drops to 0, state returns to LOAD, and in_ready=1 in the next cycle. Out data holds its last value.
- out_idx=grp. out_last=(grp==3)&out_valid.
- in_last check, evaluated on each accept:
  - in_last=1 with wr_cnt!=15 pulses frame_err.
  - in_last=0 with wr_cnt==15 pulses frame_err.
  - The count is authoritative. Framing is never resynchronised by in_last.
- Minimum frame period is 20 cycles (16 load + 4 issue), assuming in_valid and out_ready are held high.
- Reset asserted mid-frame or mid-issue: all state returns to reset values immediately and asynchronously. The partial frame is discarded.
- Data is never modified; no arithmetic is performed.

Decomposition:
- Shared package fft16_pkg holds:
  - constants DATA_W=32, N_POINTS=16, RADIX=4, GROUPS=4
  - state enum {LOAD, ISSUE}
  - the complex-word struct (real, imag)
- One sub-module, fft16_sample_buf: a 16-entry x (2*DATA_W) register file with one write port and four combinational read ports at addresses k, k+4, k+8, k+12. It has no reset.

Test Plan:
- Basic frame: samples i=0..15 with raw in_real=i and in_im=0x100+i, in_last on i=15, out_ready=1 throughout.
  - Groups appear on consecutive cycles.
  - k=0: real 0,4,8,12; im 0x100,0x104,0x108,0x10C.
  - k=3: real 3,7,11,15 with out_last=1.
  - out_valid first rises 1 cycle after the 16th accept.
- Backpressure: out_ready=0 for 5 cycles while group 1 is presented.
  - out_idx=1 and data (1,5,9,13) hold steady; in_ready stays 0.
  - When out_ready rises, group 2 follows.
- Back-to-back frames: second frame uses real=0x3F800000+i.
  - in_ready is 0 for exactly 4 cycles after frame 1 loads.
  - Frame 2, group 0 real = 0x3F800000, 0x3F800004, 0x3F800008, 0x3F80000C.
- Framing error: in_last asserted on sample 9 and absent on sample 15.
  - frame_err pulses twice, once on each of those accepts.
  - The frame still issues all 4 groups correctly.
- Reset mid-issue: rst_n low while out_idx=2.
  - out_valid=0, outputs=0 and in_ready=1 without waiting for a clock edge.
  - A fresh 16-sample frame then issues correctly from k=0.
- Idle gaps: in_valid toggles 1/0 every cycle.
  - Exactly 16 accepts are counted, and issue begins after the 16th accept.
